sdr_cmd_fsm: RTL and testbench
==============================

Name: sdr_cmd_fsm

Overview:
- Command-sequencing FSM for the SDR controller. Once initialisation reports i_ready, it accepts single read/write requests from the host-side bridge and schedules periodic auto-refresh.
- Produces the 4-bit cState that sdr_ctrl_sig decodes into SDRAM pin commands.
- Produces data-path strobes and a request acknowledge.
- Sits directly upstream of sdr_ctrl_sig, alongside the init FSM that drives iState.

Parameters:
- NUM_CLK_tRCD, 2, cycles from ACTIVE to READA/WRITEA (minimum 2).
- NUM_CLK_CL, 2, CAS latency in cycles (minimum 2; must equal MR_CAS_Latency).
- BURST_LEN, 1, data beats per access (1, 2, 4 or 8; must equal MR_Burst_Length).
- NUM_CLK_tRP, 2, cycles held after the last data beat so the auto-precharge completes (minimum 1).
- NUM_CLK_tRFC, 7, cycles from AR to the next command (minimum 2).
- REF_PERIOD, 780, ready-cycles between refresh requests.

Ports:
- pclk  in  1  controller clock.
- presetn  in  1  asynchronous active-low reset.
- iState  in  4  init FSM state; the command FSM is enabled only when iState == i_ready.
- req  in  1  access request; held high with wr and paddr stable until ack.
- wr  in  1  1 = write, 0 = read; sampled in c_idle.
- cState  out  4  command state (cmd_state_t encodings from sdr_parameters), to sdr_ctrl_sig.
- rd_dat_en  out  1  read-data capture strobe, one per beat.
- wr_dat_en  out  1  write-data drive strobe, one per beat.
- ack  out  1  one-cycle pulse when the access completes.
- ref_pending  out  1  refresh request outstanding.

Behaviour:
- Reset (presetn low, asynchronous) gives: cState = c_idle, rd_dat_en = 0, wr_dat_en = 0, ack = 0, ref_pending = 0, all counters 0. Every output is registered.
- Refresh timer:
  - Counts only while iState == i_ready and holds at 0 otherwise.
  - At count REF_PERIOD-1 it wraps to 0 and sets ref_pending.
  - ref_pending is sticky and clears on the cycle cState enters c_AR.
  - A second tick while ref_pending is still set leaves it set. There is no queueing.
- c_idle:
  - If iState != i_ready, stay in c_idle.
  - Otherwise, if ref_pending, go to c_AR. Refresh has priority over req in the same cycle.
  - Otherwise, if req, go to c_ACTIVE.
- c_ACTIVE: 1 cycle, then c_tRCD.
- c_tRCD: NUM_CLK_tRCD-1 cycles, then c_WRITEA if wr else c_READA.
- c_READA:
  - 1 cycle, then c_cl for NUM_CLK_CL-1 cycles, then c_rdata.
  - c_rdata lasts BURST_LEN+NUM_CLK_tRP cycles.
  - rd_dat_en is high during the first BURST_LEN cycles of c_rdata.
- c_WRITEA:
  - 1 cycle, then c_wdata for BURST_LEN-1+NUM_CLK_tRP cycles.
  - wr_dat_en is high in the c_WRITEA cycle and the first BURST_LEN-1 c_wdata cycles.
- Access completion:
  - ack pulses high on the final cycle of c_rdata or c_wdata.
  - The next state is c_idle.
  - A new request is never accepted in the ack cycle. The requester drops req on ack.
- c_AR: 1 cycle, then c_tRFC for NUM_CLK_tRFC-1 cycles, then c_idle.
- Strobe alignment:
  - Strobes are aligned to cState timing.
  - The data path adds the one-cycle register delay of sdr_ctrl_sig itself.
- Single down-counter:
  - One wait counter, of width $clog2 of the largest dwell, is loaded on each state entry.
  - The FSM leaves the state when the counter reaches 0.
- A refresh tick during an access sets ref_pending. The refresh is served at the next c_idle.
- iState leaves i_ready mid-operation (re-init):
  - Next cycle: cState = c_idle, strobes = 0, no ack.
  - Refresh timer cleared, ref_pending cleared.
- Reset mid-operation: immediate return to the reset values.
- Illegal or unused cState values go to c_idle.

Test Plan:
- Read (default parameters), iState = i_ready, req=1 wr=0 at T0:
  - cState is c_ACTIVE T1, c_tRCD T2, c_READA T3, c_cl T4, c_rdata T5–T7.
  - rd_dat_en=1 only at T5; ack=1 at T7; c_idle at T8.
- Write, BURST_LEN=4, req=1 wr=1:
  - c_WRITEA at T3.
  - wr_dat_en high T3–T6 (4 beats).
  - c_wdata T4–T8; ack at T8.
- Refresh, REF_PERIOD=16, no req:
  - ref_pending rises after 16 ready-cycles.
  - Next cycle c_AR and ref_pending=0.
  - c_tRFC for 6 cycles, then c_idle.
- Collision: ref_pending and req both high in c_idle:
  - c_AR first, then c_idle for one cycle.
  - c_ACTIVE after that; the request is acked normally.
- iState drops from i_ready while in c_cl:
  - Next cycle c_idle, rd_dat_en=0, ack never pulses, ref_pending=0.
- presetn low during c_wdata:
  - Outputs immediately at reset values.
  - After release, the FSM stays in c_idle until i_ready.

Source files
------------

// File: rtl/sdr_cmd_fsm.sv
// Command-sequencing FSM for the SDR controller: single read/write accesses with
// auto-precharge and periodic auto-refresh, enabled once the init FSM reports ready.
module sdr_cmd_fsm #(
    parameter int         NUM_CLK_tRCD = 2,
    parameter int         NUM_CLK_CL   = 2,
    parameter int         BURST_LEN    = 1,
    parameter int         NUM_CLK_tRP  = 2,
    parameter int         NUM_CLK_tRFC = 7,
    parameter int         REF_PERIOD   = 780,
    parameter logic [3:0] I_READY      = 4'd9
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic [3:0] iState,
    input  logic       req,
    input  logic       wr,
    output logic [3:0] cState,
    output logic       rd_dat_en,
    output logic       wr_dat_en,
    output logic       ack,
    output logic       ref_pending
);

    typedef enum logic [3:0] {
        c_idle   = 4'd0,
        c_ACTIVE = 4'd1,
        c_tRCD   = 4'd2,
        c_READA  = 4'd3,
        c_cl     = 4'd4,
        c_rdata  = 4'd5,
        c_WRITEA = 4'd6,
        c_wdata  = 4'd7,
        c_AR     = 4'd8,
        c_tRFC   = 4'd9
    } cmd_state_t;

    // Number of cycles spent in each multi-cycle state.
    localparam int DWELL_RCD = NUM_CLK_tRCD - 1;
    localparam int DWELL_CL  = NUM_CLK_CL - 1;
    localparam int DWELL_RD  = BURST_LEN + NUM_CLK_tRP;
    localparam int DWELL_WR  = BURST_LEN - 1 + NUM_CLK_tRP;
    localparam int DWELL_RFC = NUM_CLK_tRFC - 1;

    localparam int MAX_A     = (DWELL_RCD > DWELL_CL) ? DWELL_RCD : DWELL_CL;
    localparam int MAX_B     = (DWELL_RD > DWELL_RFC) ? DWELL_RD : DWELL_RFC;
    localparam int MAX_DWELL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int WAIT_W    = (MAX_DWELL > 2) ? $clog2(MAX_DWELL) : 1;
    localparam int REF_W     = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;

    // The wait counter is loaded with dwell-1 so that the state is left when it reads 0.
    localparam logic [WAIT_W-1:0] LD_RCD = WAIT_W'(DWELL_RCD - 1);
    localparam logic [WAIT_W-1:0] LD_CL  = WAIT_W'(DWELL_CL - 1);
    localparam logic [WAIT_W-1:0] LD_RD  = WAIT_W'(DWELL_RD - 1);
    localparam logic [WAIT_W-1:0] LD_WR  = WAIT_W'(DWELL_WR - 1);
    localparam logic [WAIT_W-1:0] LD_RFC = WAIT_W'(DWELL_RFC - 1);
    localparam logic [WAIT_W-1:0] TRP_W  = WAIT_W'(NUM_CLK_tRP);
    localparam logic [WAIT_W-1:0] ONE_W  = WAIT_W'(1);
    localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REF_PERIOD - 1);

    cmd_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic              is_write;

    assign cState = state;

    // Single FSM register block. Strobes and ack are computed for the state being
    // entered, so they line up with cState. A refresh tick landing on the same edge
    // that enters c_AR is absorbed by that refresh (later assignment wins).
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= c_idle;
            wait_cnt    <= '0;
            ref_cnt     <= '0;
            is_write    <= 1'b0;
            rd_dat_en   <= 1'b0;
            wr_dat_en   <= 1'b0;
            ack         <= 1'b0;
            ref_pending <= 1'b0;
        end else if (iState != I_READY) begin
            state       <= c_idle;
            wait_cnt    <= '0;
            ref_cnt     <= '0;
            is_write    <= 1'b0;
            rd_dat_en   <= 1'b0;
            wr_dat_en   <= 1'b0;
            ack         <= 1'b0;
            ref_pending <= 1'b0;
        end else begin
            if (ref_cnt == REF_LAST) begin
                ref_cnt     <= '0;
                ref_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            rd_dat_en <= 1'b0;
            wr_dat_en <= 1'b0;
            ack       <= 1'b0;

            case (state)
                c_idle: begin
                    wait_cnt <= '0;
                    if (ref_pending) begin
                        state       <= c_AR;
                        ref_pending <= 1'b0;
                    end else if (req) begin
                        state    <= c_ACTIVE;
                        is_write <= wr;
                    end
                end
                c_ACTIVE: begin
                    state    <= c_tRCD;
                    wait_cnt <= LD_RCD;
                end
                c_tRCD: begin
                    if (wait_cnt == '0) begin
                        if (is_write) begin
                            state     <= c_WRITEA;
                            wr_dat_en <= 1'b1;
                        end else begin
                            state <= c_READA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - ONE_W;
                    end
                end
                c_READA: begin
                    state    <= c_cl;
                    wait_cnt <= LD_CL;
                end
                c_cl: begin
                    if (wait_cnt == '0) begin
                        state     <= c_rdata;
                        wait_cnt  <= LD_RD;
                        rd_dat_en <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - ONE_W;
                    end
                end
                c_rdata: begin
                    if (wait_cnt == '0) begin
                        state <= c_idle;
                    end else begin
                        wait_cnt  <= wait_cnt - ONE_W;
                        rd_dat_en <= (wait_cnt > TRP_W);
                        ack       <= (wait_cnt == ONE_W);
                    end
                end
                c_WRITEA: begin
                    state     <= c_wdata;
                    wait_cnt  <= LD_WR;
                    wr_dat_en <= (LD_WR >= TRP_W);
                    ack       <= (LD_WR == '0);
                end
                c_wdata: begin
                    if (wait_cnt == '0) begin
                        state <= c_idle;
                    end else begin
                        wait_cnt  <= wait_cnt - ONE_W;
                        wr_dat_en <= (wait_cnt > TRP_W);
                        ack       <= (wait_cnt == ONE_W);
                    end
                end
                c_AR: begin
                    state    <= c_tRFC;
                    wait_cnt <= LD_RFC;
                end
                c_tRFC: begin
                    if (wait_cnt == '0) begin
                        state <= c_idle;
                    end else begin
                        wait_cnt <= wait_cnt - ONE_W;
                    end
                end
                default: begin
                    state    <= c_idle;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_cmd_fsm.sv
// Randomized self-checking bench for sdr_cmd_fsm: a schedule-based model predicts
// cState, strobes, ack and ref_pending every cycle.
module tb_sdr_cmd_fsm;

    localparam int         TRCD  = 2;
    localparam int         CL    = 2;
    localparam int         BL    = 4;
    localparam int         TRP   = 2;
    localparam int         TRFC  = 7;
    localparam int         REFP  = 48;
    localparam int         NCYC  = 4000;
    localparam logic [3:0] I_READY = 4'd9;

    localparam logic [3:0] C_IDLE = 4'd0, C_ACTIVE = 4'd1, C_TRCD = 4'd2, C_READA = 4'd3,
                           C_CL = 4'd4, C_RDATA = 4'd5, C_WRITEA = 4'd6, C_WDATA = 4'd7,
                           C_AR = 4'd8, C_TRFC = 4'd9;

    typedef struct packed {
        logic [3:0] st;
        logic       rd;
        logic       wr;
        logic       ak;
    } exp_t;

    logic       pclk = 1'b0;
    logic       presetn = 1'b1;
    logic [3:0] iState = 4'd0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] cState;
    logic       rd_dat_en, wr_dat_en, ack, ref_pending;

    sdr_cmd_fsm #(
        .NUM_CLK_tRCD(TRCD), .NUM_CLK_CL(CL), .BURST_LEN(BL), .NUM_CLK_tRP(TRP),
        .NUM_CLK_tRFC(TRFC), .REF_PERIOD(REFP), .I_READY(I_READY)
    ) dut (
        .pclk(pclk), .presetn(presetn), .iState(iState), .req(req), .wr(wr),
        .cState(cState), .rd_dat_en(rd_dat_en), .wr_dat_en(wr_dat_en),
        .ack(ack), .ref_pending(ref_pending)
    );

    always #5 pclk = ~pclk;

    int   checks = 0;
    int   errors = 0;
    exp_t cur;
    exp_t plan[$];
    int   timer;
    bit   pending;
    int   not_ready_left = 3;
    bit   last_ack = 1'b0;
    bit   did_cl_drop = 1'b0;
    bit   did_wdata_reset = 1'b0;
    bit   release_reset = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic rd, input logic w, input logic ak);
        exp_t e;
        e.st = st; e.rd = rd; e.wr = w; e.ak = ak;
        return e;
    endfunction

    task automatic modelReset();
        plan.delete();
        cur     = mk(C_IDLE, 1'b0, 1'b0, 1'b0);
        timer   = 0;
        pending = 1'b0;
    endtask

    // Whole-access schedule derived from the command timing rules.
    task automatic pushAccess(input bit is_wr);
        plan.push_back(mk(C_ACTIVE, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < TRCD - 1; i++) plan.push_back(mk(C_TRCD, 1'b0, 1'b0, 1'b0));
        if (!is_wr) begin
            plan.push_back(mk(C_READA, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < CL - 1; i++) plan.push_back(mk(C_CL, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < BL + TRP; i++)
                plan.push_back(mk(C_RDATA, i < BL, 1'b0, i == BL + TRP - 1));
        end else begin
            plan.push_back(mk(C_WRITEA, 1'b0, 1'b1, 1'b0));
            for (int i = 0; i < BL - 1 + TRP; i++)
                plan.push_back(mk(C_WDATA, 1'b0, i < BL - 1, i == BL + TRP - 2));
        end
    endtask

    task automatic modelStep(input bit ready, input bit req_in, input bit wr_in);
        bit old_pending, tick, enter_ar;
        if (!ready) begin
            modelReset();
            return;
        end
        old_pending = pending;
        tick        = (timer == REFP - 1);
        timer       = tick ? 0 : timer + 1;
        enter_ar    = 1'b0;
        if (plan.size() == 0 && cur.st == C_IDLE) begin
            if (old_pending) begin
                plan.push_back(mk(C_AR, 1'b0, 1'b0, 1'b0));
                for (int i = 0; i < TRFC - 1; i++) plan.push_back(mk(C_TRFC, 1'b0, 1'b0, 1'b0));
                enter_ar = 1'b1;
            end else if (req_in) begin
                pushAccess(wr_in);
            end
        end
        cur     = (plan.size() > 0) ? plan.pop_front() : mk(C_IDLE, 1'b0, 1'b0, 1'b0);
        pending = (old_pending | tick) & ~enter_ar;
    endtask

    task automatic compareAll(input string phase);
        checkOutput({phase, ".cState"}, 32'(cState), 32'(cur.st));
        checkOutput({phase, ".rd_dat_en"}, 32'(rd_dat_en), 32'(cur.rd));
        checkOutput({phase, ".wr_dat_en"}, 32'(wr_dat_en), 32'(cur.wr));
        checkOutput({phase, ".ack"}, 32'(ack), 32'(cur.ak));
        checkOutput({phase, ".ref_pending"}, 32'(ref_pending), 32'(pending));
    endtask

    task automatic applyStimulus();
        if (release_reset) begin
            presetn        = 1'b1;
            release_reset  = 1'b0;
            not_ready_left = 2;
        end
        if (!did_cl_drop && cur.st == C_CL) begin
            did_cl_drop    = 1'b1;
            not_ready_left = 2;
        end else if (not_ready_left == 0 && $urandom_range(0, 249) == 0) begin
            not_ready_left = $urandom_range(1, 4);
        end
        if (not_ready_left > 0) begin
            iState = 4'($urandom_range(0, 8));
            not_ready_left--;
        end else begin
            iState = I_READY;
        end
        if (req && last_ack) begin
            req = 1'b0;
        end else if (!req && ($urandom_range(0, 3) == 0 || (pending && $urandom_range(0, 1) == 0))) begin
            req = 1'b1;
            wr  = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        modelReset();
        #2 presetn = 1'b0;
        repeat (2) @(negedge pclk);
        compareAll("reset");
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge pclk);
            if (cyc == 0) presetn = 1'b1;
            applyStimulus();
            @(posedge pclk);
            modelStep(iState == I_READY, req, wr);
            #1;
            compareAll("cycle");
            last_ack = ack;
            if ((!did_wdata_reset && cur.st == C_WDATA) || $urandom_range(0, 599) == 0) begin
                did_wdata_reset = 1'b1;
                #2 presetn = 1'b0;
                #1;
                modelReset();
                compareAll("midreset");
                last_ack      = 1'b0;
                release_reset = 1'b1;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
